// File: rtl/pearl_mem_pkg.sv
// pearl_mem_pkg
//   Shared types and constants for the data-memory responder slice.
//   - access_size_e : load/store access width encoding carried on req_size_i
//   - dmem_state_e  : responder FSM states
//   - WORD_W        : data word width in bits
//   - strb_to_mask  : expands a 4-bit byte strobe into a 32-bit bit mask
package pearl_mem_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } access_size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  // Each strobe bit covers one byte lane of the word; the resulting mask
  // lets a byte-strobed store be written as a single read-modify-write.
  function automatic logic [WORD_W-1:0] strb_to_mask(input logic [BYTES_PER_WORD-1:0] strb);
    logic [WORD_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_responder_load_align.sv
// load_align
//   Combinational load-data alignment. Shifts the addressed byte or
//   halfword down to bit 0 and zero- or sign-extends it to a full word.
//   Ports:
//     word        in  32  raw SRAM word
//     lane        in  2   byte lane of the access (addr[1:0])
//     size        in  2   access size, see access_size_e; 2'b11 behaves as word
//     is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//     rdata       out 32  aligned, extended load data
module load_align
  import pearl_mem_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] byte_w;
  logic [WORD_W-1:0] half_w;
  logic              sext;

  // Halfword accesses are naturally aligned, so only lane[1] selects which
  // half; lane[0] is deliberately ignored for them.
  always_comb begin
    sext   = ~is_unsigned;
    byte_w = word >> {lane, 3'b000};
    half_w = lane[1] ? (word >> 16) : word;
    rdata  = word;
    case (access_size_e'(size))
      SZ_BYTE: rdata = {{24{sext & byte_w[7]}}, byte_w[7:0]};
      SZ_HALF: rdata = {{16{sext & half_w[15]}}, half_w[15:0]};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side end of the LSU load/store interface. Accepts one
//   word-aligned request per handshake, applies byte-strobed stores to an
//   on-chip word SRAM, and returns exactly one response per request (loads
//   return lane-aligned, extended data; stores return zero).
//
//   Optional feature (macro DMEM_ERR_RESP_EN):
//     defined   - out-of-window addresses respond with rsp_err_o=1, rdata=0,
//                 and stores to them are dropped
//     undefined - rsp_err_o is always 0 and addresses alias modulo depth
//
//   Parameters:
//     DEPTH_WORDS  SRAM depth in words (power of two, >= 4)
//     WAIT_CYCLES  extra cycles between accept and response (0..15)
//     BASE_ADDR    byte address of word 0 (DEPTH_WORDS*4 aligned)
//
//   Ports:
//     clk_i          in   1   clock, rising edge
//     rst_ni         in   1   asynchronous reset, active low
//     req_valid_i    in   1   request valid
//     req_ready_o    out  1   request can be accepted (IDLE only)
//     req_we_i       in   1   1 = store, 0 = load
//     req_addr_i     in   32  byte address, [1:0] ignored
//     req_strb_i     in   4   store byte enables
//     req_wdata_i    in   32  lane-positioned store data
//     req_lane_i     in   2   load byte lane
//     req_size_i     in   2   access size
//     req_unsigned_i in   1   1 = zero-extend load
//     rsp_valid_o    out  1   response valid
//     rsp_ready_i    in   1   response accepted
//     rsp_rdata_o    out  32  load data, 0 for stores and errors
//     rsp_err_o      out  1   access error
module dmem_responder
  import pearl_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_strb_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_lane_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  dmem_state_e       state;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic              err_q;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] aligned;

  logic [31:0]       offset;
  logic [IDX_W-1:0]  idx;
  logic              addr_err;
  logic              accept;
  logic              wr_en;

  // Word index relative to the window base. Addresses below the base wrap to
  // large offsets, so one upper-bits test covers both sides of the window.
  assign offset = req_addr_i - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];

`ifdef DMEM_ERR_RESP_EN
  logic unused_offset;
  assign addr_err      = (offset[31:IDX_W+2] != '0);
  assign unused_offset = ^offset[1:0];
`else
  logic unused_offset;
  assign addr_err      = 1'b0;
  assign unused_offset = ^{offset[31:IDX_W+2], offset[1:0]};
`endif

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i & req_ready_o;
  assign wr_en       = accept & req_we_i & ~addr_err;

  // Behavioural SRAM write port. Stores commit on the accept edge, so a
  // later reset cannot undo them; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[idx] <= (mem[idx] & ~strb_to_mask(req_strb_i))
                | (req_wdata_i & strb_to_mask(req_strb_i));
    end
  end

  // Responder FSM and the latched request. The SRAM read data register lives
  // here too so that it is cleared by reset and the response data path reads
  // zero until the first load completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rsp_valid_o <= 1'b0;
      we_q        <= 1'b0;
      lane_q      <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      err_q       <= 1'b0;
      rd_word     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q       <= req_we_i;
            lane_q     <= req_lane_i;
            size_q     <= req_size_i;
            unsigned_q <= req_unsigned_i;
            err_q      <= addr_err;
            if (!req_we_i) begin
              rd_word <= mem[idx];
            end
            if (WAIT_CYCLES == 0) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

  load_align u_load_align (
    .word        (rd_word),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .rdata       (aligned)
  );

  // Response data only depends on registers latched at accept, so it stays
  // stable for the whole RESP phase regardless of rsp_ready_i.
  assign rsp_rdata_o = (we_q | err_q) ? '0 : aligned;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Directed, scoreboard-based bench for dmem_responder with WAIT_CYCLES=2.
//   Expected responses are queued when a request is accepted and compared
//   when the responder presents them.
module tb_dmem_responder;

  localparam int          DEPTH = 64;
  localparam int          WAITC = 2;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] TOP   = BASE + 32'(4 * (DEPTH - 1));
`ifdef DMEM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_strb = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_lane = '0;
  logic [1:0]  req_size = '0;
  logic        req_uns = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITC),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_strb_i     (req_strb),
    .req_wdata_i    (req_wdata),
    .req_lane_i     (req_lane),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request, holds it through the accept edge and queues the
  // response the bench expects for it.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                               input logic [31:0] wdata, input logic [1:0] lane,
                               input logic [1:0] size, input logic uns,
                               input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_strb  = strb;
    req_wdata = wdata;
    req_lane  = lane;
    req_size  = size;
    req_uns   = uns;
    req_valid = 1'b1;
    check("ready before accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; counts edges until the response shows.
  task automatic waitResponse(input string tag);
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(WAITC));
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("[TB] FAIL %s: observed response with empty scoreboard, expected none", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, " valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rdata"}, rsp_rdata, e.rdata);
    check({tag, " err"}, 32'(rsp_err), 32'(e.err));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, " valid drop"}, 32'(rsp_valid), 32'd0);
    check({tag, " ready back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [3:0] strb, input logic [31:0] wdata, input logic [1:0] lane,
                      input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_rdata, input logic exp_err);
    applyStimulus(we, addr, strb, wdata, lane, size, uns, exp_rdata, exp_err);
    waitResponse(tag);
    checkOutput(tag);
  endtask

  initial begin
    // Reset state
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready after reset", 32'(req_ready), 32'd1);

    // Word store then load
    xact("st word", 1'b1, BASE + 8, 4'b1111, 32'hDEAD_BEEF, 2'd0, 2'b10, 1'b0, 32'h0, 1'b0);
    xact("ld word", 1'b0, BASE + 8, 4'b0000, 32'h0, 2'd0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Byte store into lane 2, then byte loads
    xact("st byte", 1'b1, BASE + 8, 4'b0100, 32'h0080_0000, 2'd2, 2'b00, 1'b0, 32'h0, 1'b0);
    xact("ld byte s", 1'b0, BASE + 8, 4'b0000, 32'h0, 2'd2, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0);
    xact("ld byte u", 1'b0, BASE + 8, 4'b0000, 32'h0, 2'd2, 2'b00, 1'b1, 32'h0000_0080, 1'b0);
    xact("ld byte l0", 1'b0, BASE + 8, 4'b0000, 32'h0, 2'd0, 2'b00, 1'b0, 32'hFFFF_FFEF, 1'b0);
    xact("ld after byte", 1'b0, BASE + 8, 4'b0000, 32'h0, 2'd0, 2'b10, 1'b0, 32'hDE80_BEEF, 1'b0);

    // Halfword loads
    xact("st half word", 1'b1, BASE + 12, 4'b1111, 32'h8001_7FFF, 2'd0, 2'b10, 1'b0, 32'h0, 1'b0);
    xact("ld half l0 s", 1'b0, BASE + 12, 4'b0000, 32'h0, 2'd0, 2'b01, 1'b0, 32'h0000_7FFF, 1'b0);
    xact("ld half l2 s", 1'b0, BASE + 12, 4'b0000, 32'h0, 2'd2, 2'b01, 1'b0, 32'hFFFF_8001, 1'b0);
    xact("ld half l2 u", 1'b0, BASE + 12, 4'b0000, 32'h0, 2'd2, 2'b01, 1'b1, 32'h0000_8001, 1'b0);
    xact("ld half l3 s", 1'b0, BASE + 12, 4'b0000, 32'h0, 2'd3, 2'b01, 1'b0, 32'hFFFF_8001, 1'b0);
    xact("ld size11", 1'b0, BASE + 12, 4'b0000, 32'h0, 2'd2, 2'b11, 1'b0, 32'h8001_7FFF, 1'b0);

    // Empty strobe still responds and leaves memory alone
    xact("st strb0", 1'b1, BASE + 12, 4'b0000, 32'h1234_5678, 2'd0, 2'b10, 1'b0, 32'h0, 1'b0);
    xact("ld after strb0", 1'b0, BASE + 12, 4'b0000, 32'h0, 2'd0, 2'b10, 1'b0, 32'h8001_7FFF, 1'b0);

    // Backpressure: response held, a stray store request is ignored
    applyStimulus(1'b0, BASE + 8, 4'b0000, 32'h0, 2'd0, 2'b10, 1'b0, 32'hDE80_BEEF, 1'b0);
    waitResponse("bp");
    for (int i = 0; i < 5; i++) begin
      check("bp hold valid", 32'(rsp_valid), 32'd1);
      check("bp hold rdata", rsp_rdata, 32'hDE80_BEEF);
      check("bp ready low", 32'(req_ready), 32'd0);
      if (i == 2) begin
        @(negedge clk);
        req_we    = 1'b1;
        req_addr  = BASE + 8;
        req_strb  = 4'b1111;
        req_wdata = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #6;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("bp");
    xact("ld after bp", 1'b0, BASE + 8, 4'b0000, 32'h0, 2'd0, 2'b10, 1'b0, 32'hDE80_BEEF, 1'b0);

    // Out-of-window access below the base
    xact("st top", 1'b1, TOP, 4'b1111, 32'hA5A5_A5A5, 2'd0, 2'b10, 1'b0, 32'h0, 1'b0);
    xact("st below base", 1'b1, BASE - 4, 4'b1111, 32'h1122_3344, 2'd0, 2'b10, 1'b0, 32'h0, ERR_EN);
    xact("ld top", 1'b0, TOP, 4'b0000, 32'h0, 2'd0, 2'b10, 1'b0,
         ERR_EN ? 32'hA5A5_A5A5 : 32'h1122_3344, 1'b0);
    xact("ld below base", 1'b0, BASE - 4, 4'b0000, 32'h0, 2'd0, 2'b10, 1'b0,
         ERR_EN ? 32'h0 : 32'h1122_3344, ERR_EN);

    // Reset while a response is pending
    applyStimulus(1'b0, BASE - 4, 4'b0000, 32'h0, 2'd0, 2'b10, 1'b0, 32'h0, ERR_EN);
    waitResponse("rst mid");
    check("rst mid valid before", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mid valid", 32'(rsp_valid), 32'd0);
    check("rst mid err", 32'(rsp_err), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst mid ready", 32'(req_ready), 32'd1);
    xact("ld after rst", 1'b0, BASE + 8, 4'b0000, 32'h0, 2'd0, 2'b10, 1'b0, 32'hDE80_BEEF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
